mac_out_pack: RTL and testbench
===============================

# mac_out_pack

Output packing buffer directly downstream of MAC stage 5. Packs the 16-bit MAC results (`o_conv`/`o_valid` of stage 5) into 64-bit words, four results per word, and queues them in a small FIFO for the output write port. When the FIFO is full it raises `o_inhibit`, which drives the `i_inhibit` input of every MAC pipeline stage and freezes the pipeline.

## Interface
- `DEPTH`, default 4: FIFO depth in 64-bit words; must be a power of two and at least 2.
- `i_clk`  input  1  clock; all state updates on its rising edge.
- `i_rst_n`  input  1  reset, synchronous, active-low.
- `i_valid`  input  1  stage-5 result valid.
- `i_conv`  input  16  stage-5 MAC result.
- `i_flush`  input  1  end of output tile; emit the partial word.
- `i_ready`  input  1  downstream accepts `o_data` this cycle.
- `o_inhibit`  output  1  pipeline stall, fanned out to every stage's `i_inhibit`.
- `o_valid`  output  1  FIFO head is valid.
- `o_data`  output  64  FIFO head word.
- `o_keep`  output  4  valid-lane mask of the head word; bit k covers `o_data[16k+15:16k]`.

## Operation
- **Packer state.**
  - `lane_cnt` is 2 bits, range 0–3.
  - `pack_buf` holds lanes 0–2.
- **Accept.**
  - A result is accepted when `i_valid && !o_inhibit`.
  - When inhibited, stage 5 holds `i_valid`/`i_conv`, so nothing is lost.
- **Accept with `lane_cnt` < 3.**
  - Write `i_conv` into lane `lane_cnt`.
  - Increment `lane_cnt`.
- **Accept with `lane_cnt` == 3.**
  - Push `{i_conv, pack_buf[2], pack_buf[1], pack_buf[0]}` with keep `4'b1111`.
  - Set `lane_cnt` to 0.
- **Lane order.** The first result of a word goes to bits [15:0]; the fourth goes to bits [63:48].
- **Flush.**
  - A flush is taken when `i_flush && !o_inhibit`.
  - If a result is accepted in the same cycle, it is included first.
  - If the total lane count n is 1–3, push the partial word with unused lanes zero and keep = (1<<n)-1, then set `lane_cnt` to 0.
  - If n is 0 or 4, no extra push. A full word is pushed normally, and an empty packer produces nothing.
  - At most one push occurs per cycle.
- **FIFO.**
  - `DEPTH` entries of {keep, data}.
  - Write pointer, read pointer and count of width log2(`DEPTH`)+1.
  - Pop when `o_valid && i_ready`.
  - Push and pop in the same cycle leave the count unchanged.
- **Stall.**
  - `o_inhibit` = (count == `DEPTH`).
  - The stall is conservative: it asserts even if the packer could absorb lanes without pushing.
  - A push is therefore never attempted on a full FIFO, and no overflow path exists.
- **Outputs.**
  - `o_valid` = (count != 0).
  - `o_data` and `o_keep` show the head entry. When the FIFO is empty they are 0.
- **Reset.**
  - While `i_rst_n` is low at a rising edge: `lane_cnt`, `pack_buf`, pointers, count and all FIFO entries are cleared.
  - Outputs then read `o_inhibit`=0, `o_valid`=0, `o_data`=0, `o_keep`=0.
  - Reset mid-operation discards partial words and queued words without emitting them.
  - `i_ready` is ignored during reset.

## Timing
- **Push latency.** A push caused in cycle t makes `o_valid`=1 from cycle t+1, provided the FIFO was empty.
- **Stall assertion.** `o_inhibit` rises in the cycle after the push that fills the FIFO.
  - That push's result was accepted legally because the FIFO was not yet full.
- **Stall release.** `o_inhibit` drops in the cycle after the first pop from a full FIFO.
  - Accept resumes that cycle.
  - There is no combinational path from `i_ready` to `o_inhibit`.
- **Throughput.** One result per cycle; sustained output is one word per 4 cycles.
- **Handshake.**
  - `o_data` and `o_keep` are stable while `o_valid && !i_ready`.
  - Downstream may hold `i_ready` low indefinitely.
- **Inputs while stalled.** `i_valid` and `i_flush` are ignored while `o_inhibit`=1, and the source must hold them.

## Test plan
- **Basic pack.** Results 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with `i_ready`=1.
  - Required: next cycle `o_data`=0x4444_3333_2222_1111, `o_keep`=4'b1111, `o_valid` high for exactly 1 cycle.
- **Partial flush.** Results 0xAAAA then 0xBBBB, then `i_flush` alone.
  - Required: `o_data`=0x0000_0000_BBBB_AAAA, `o_keep`=4'b0011.
- **Flush with result.** `i_flush` together with the 3rd result 0x0003.
  - Required: a single word with keep 4'b0111 and lane 2 = 0x0003, followed by no further word.
  - Also required: `i_flush` on an empty packer produces no output.
- **Back-pressure.** `DEPTH`=4, `i_ready`=0, 16 results streamed.
  - Required: `o_inhibit`=1 the cycle after the 4th push; results 17 onward are held by the source and not lost.
  - Then raise `i_ready` for 1 cycle. Required: one pop, `o_inhibit` drops the next cycle, the held result is accepted, and all words drain in order.
- **Simultaneous push and pop.** Count=2, a push and a pop in the same cycle.
  - Required: count stays 2 and the word order is preserved.
- **Reset mid-operation.** Assert `i_rst_n`=0 with 2 lanes packed and 3 words queued.
  - Required: on the next edge all outputs are 0, and the next 4 results form a fresh word with no stale lanes.

Source files
------------

// File: rtl/mac_out_pack.sv
// Packs 16-bit MAC stage-5 results four per 64-bit word and queues the words in a DEPTH-entry FIFO.
// A push is visible on o_valid the next cycle; a full FIFO raises o_inhibit, which freezes the MAC pipeline.
module mac_out_pack #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_conv,
  input  logic        i_flush,
  input  logic        i_ready,
  output logic        o_inhibit,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic [3:0]  o_keep
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  keep;
    logic [63:0] data;
  } entry_t;

  logic [1:0]       lane_cnt_q, lane_cnt_d;
  logic [2:0][15:0] pack_buf_q, pack_buf_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             flush_take;
  logic             push;
  logic             pop;
  logic [2:0]       n_lanes;
  entry_t           push_entry;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  // Stall is taken from the registered count only, so i_ready never reaches o_inhibit combinationally.
  assign o_inhibit  = (cnt_q == CW'(DEPTH));
  assign o_valid    = (cnt_q != '0);
  assign accept     = i_valid && !o_inhibit;
  assign flush_take = i_flush && !o_inhibit;
  assign pop        = o_valid && i_ready;
  assign wr_idx     = wr_ptr_q[AW-1:0];
  assign rd_idx     = rd_ptr_q[AW-1:0];

  always_comb begin
    n_lanes    = {1'b0, lane_cnt_q} + {2'b00, accept};
    push_entry = '0;
    // Lanes at or above lane_cnt are never read from pack_buf, so stale lanes cannot leak into a word.
    for (int k = 0; k < 3; k++) begin
      if (2'(k) < lane_cnt_q) begin
        push_entry.data[16*k +: 16] = pack_buf_q[k];
      end else if (accept && (2'(k) == lane_cnt_q)) begin
        push_entry.data[16*k +: 16] = i_conv;
      end
    end
    if (accept && (lane_cnt_q == 2'd3)) begin
      push_entry.data[63:48] = i_conv;
    end
    case (n_lanes)
      3'd1:    push_entry.keep = 4'b0001;
      3'd2:    push_entry.keep = 4'b0011;
      3'd3:    push_entry.keep = 4'b0111;
      3'd4:    push_entry.keep = 4'b1111;
      default: push_entry.keep = 4'b0000;
    endcase
    push = (n_lanes == 3'd4) || (flush_take && (n_lanes != 3'd0));

    lane_cnt_d = lane_cnt_q;
    pack_buf_d = pack_buf_q;
    if (push || flush_take) begin
      lane_cnt_d = 2'd0;
    end else if (accept) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) == lane_cnt_q) begin
          pack_buf_d[k] = i_conv;
        end
      end
      lane_cnt_d = lane_cnt_q + 2'd1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_idx] = push_entry;
    end
    wr_ptr_d = wr_ptr_q + CW'(push);
    rd_ptr_d = rd_ptr_q + CW'(pop);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    o_data = '0;
    o_keep = '0;
    if (o_valid) begin
      o_data = mem_q[rd_idx].data;
      o_keep = mem_q[rd_idx].keep;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lane_cnt_q <= '0;
      pack_buf_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      lane_cnt_q <= lane_cnt_d;
      pack_buf_q <= pack_buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mac_out_pack.sv
// Scoreboard bench for mac_out_pack: a reference packer queues expected words as results are accepted.
// Words are compared when the DUT hands them off (o_valid && i_ready), sampled on the falling edge.
module tb_mac_out_pack;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [15:0] i_conv;
  logic        i_flush;
  logic        i_ready;
  logic        o_inhibit;
  logic        o_valid;
  logic [63:0] o_data;
  logic [3:0]  o_keep;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [67:0] exp_q [$];
  int          m_cnt = 0;
  logic [15:0] m_lane [4];

  always #5 clk = ~clk;

  mac_out_pack #(.DEPTH(DEPTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .i_conv   (i_conv),
    .i_flush  (i_flush),
    .i_ready  (i_ready),
    .o_inhibit(o_inhibit),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_keep   (o_keep)
  );

  task automatic check_val(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference packer, advanced only for results the DUT actually accepts.
  task automatic model_step(input logic v, input logic [15:0] d, input logic f);
    logic [63:0] w;
    logic [3:0]  kp;
    if (v) begin
      m_lane[m_cnt] = d;
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back({4'hF, m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
        m_cnt = 0;
      end
    end
    if (f && (m_cnt != 0)) begin
      w  = '0;
      kp = '0;
      for (int k = 0; k < m_cnt; k++) begin
        w[16*k +: 16] = m_lane[k];
        kp[k]         = 1'b1;
      end
      exp_q.push_back({kp, w});
      m_cnt = 0;
    end
  endtask

  // Source behaviour: hold inputs until a falling edge sees no stall; the next rising edge accepts them.
  task automatic drive(input logic v, input logic [15:0] d, input logic f);
    int g;
    g       = 0;
    i_valid = v;
    i_conv  = d;
    i_flush = f;
    @(negedge clk);
    while (o_inhibit && (g < 500)) begin
      @(negedge clk);
      g++;
    end
    if (o_inhibit) begin
      check_val("accept_timeout", 68'(o_inhibit), 68'd0);
    end else begin
      model_step(v, d, f);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (((exp_q.size() != 0) || o_valid) && (g < 200)) begin
      @(posedge clk);
      #1;
      g++;
    end
    check_val("drain_empty", 68'(exp_q.size()), 68'd0);
    check_val("drain_valid", 68'(o_valid), 68'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_word", 68'(o_valid), 68'd0);
      end else begin
        check_val("word", {o_keep, o_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_conv  = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_inhibit", 68'(o_inhibit), 68'd0);
    check_val("rst_valid",   68'(o_valid),   68'd0);
    check_val("rst_data",    68'(o_data),    68'd0);
    check_val("rst_keep",    68'(o_keep),    68'd0);
    rst_n = 1'b1;

    // Basic pack: four consecutive results, word valid for exactly one cycle.
    i_ready = 1'b1;
    drive(1'b1, 16'h1111, 1'b0);
    drive(1'b1, 16'h2222, 1'b0);
    drive(1'b1, 16'h3333, 1'b0);
    drive(1'b1, 16'h4444, 1'b0);
    check_val("basic_valid", 68'(o_valid), 68'd1);
    check_val("basic_data",  68'(o_data),  68'h4444_3333_2222_1111);
    check_val("basic_keep",  68'(o_keep),  68'hF);
    @(posedge clk);
    #1;
    check_val("basic_one_cycle", 68'(o_valid), 68'd0);

    // Partial flush of two lanes.
    drive(1'b1, 16'hAAAA, 1'b0);
    drive(1'b1, 16'hBBBB, 1'b0);
    drive(1'b0, 16'h0000, 1'b1);
    check_val("pflush_data", 68'(o_data), 68'h0000_0000_BBBB_AAAA);
    check_val("pflush_keep", 68'(o_keep), 68'h3);
    repeat (2) @(posedge clk);
    #1;

    // Flush together with the third result, then a flush on an empty packer.
    drive(1'b1, 16'h0001, 1'b0);
    drive(1'b1, 16'h0002, 1'b0);
    drive(1'b1, 16'h0003, 1'b1);
    check_val("fres_data", 68'(o_data), 68'h0000_0003_0002_0001);
    check_val("fres_keep", 68'(o_keep), 68'h7);
    @(posedge clk);
    #1;
    check_val("fres_single", 68'(o_valid), 68'd0);
    drive(1'b0, 16'h0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_val("empty_flush", 68'(o_valid), 68'd0);

    // Back-pressure: 16 results fill the FIFO; the 17th is held until one pop.
    i_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0);
      if (i == 11) check_val("bp_three_words", 68'(o_inhibit), 68'd0);
    end
    check_val("bp_inhibit", 68'(o_inhibit), 68'd1);
    fork
      begin
        drive(1'b1, 16'h0110, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check_val("bp_hold", 68'(o_inhibit), 68'd1);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check_val("bp_release", 68'(o_inhibit), 68'd0);
      end
    join
    for (int i = 17; i < 20; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 1'b0);
    end
    check_val("bp_refill", 68'(o_inhibit), 68'd1);
    i_ready = 1'b1;
    wait_drain();

    // Simultaneous push and pop with two words queued.
    i_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 16'(16'h2000 + i), 1'b0);
    end
    i_ready = 1'b1;
    drive(1'b1, 16'h200B, 1'b0);
    i_ready = 1'b0;
    check_val("pp_no_stall", 68'(o_inhibit), 68'd0);
    for (int i = 12; i < 16; i++) begin
      drive(1'b1, 16'(16'h2000 + i), 1'b0);
    end
    check_val("pp_count3", 68'(o_inhibit), 68'd0);
    for (int i = 16; i < 20; i++) begin
      drive(1'b1, 16'(16'h2000 + i), 1'b0);
    end
    check_val("pp_count4", 68'(o_inhibit), 68'd1);
    i_ready = 1'b1;
    wait_drain();

    // Reset with three words queued and two lanes packed.
    i_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 16'(16'h3000 + i), 1'b0);
    end
    rst_n = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #1;
    check_val("mrst_inhibit", 68'(o_inhibit), 68'd0);
    check_val("mrst_valid",   68'(o_valid),   68'd0);
    check_val("mrst_data",    68'(o_data),    68'd0);
    check_val("mrst_keep",    68'(o_keep),    68'd0);
    rst_n   = 1'b1;
    i_ready = 1'b1;
    drive(1'b1, 16'hC001, 1'b0);
    drive(1'b1, 16'hC002, 1'b0);
    drive(1'b1, 16'hC003, 1'b0);
    drive(1'b1, 16'hC004, 1'b0);
    check_val("mrst_fresh_data", 68'(o_data), 68'hC004_C003_C002_C001);
    check_val("mrst_fresh_keep", 68'(o_keep), 68'hF);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
